// File: rtl/mem_stage_hs.sv
// Memory pipeline stage between EX and WB: handshaked data-bus access with byte
// lanes, load alignment/extension, misalign and timeout errors, branch resolution.
module mem_stage_hs #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      rs2_data,
  input  logic [DATA_W-1:0]      pc_incr_in,
  input  logic [DATA_W-1:0]      pc_offset_in,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             rw_type,
  input  logic                   branch,
  input  logic                   jump,
  input  logic [2:0]             br_cond,
  input  logic                   zero,
  input  logic                   lt,
  input  logic                   ltu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic [DATA_W-1:0]      pc_incr_out,
  output logic                   pc_src,
  output logic [DATA_W-1:0]      pc_target,
  output logic                   misalign,
  output logic                   bus_err,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [DATA_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  output logic [DATA_W/8-1:0]    bus_be,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_rdata
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LSB_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [LSB_W-1:0]  r_off;
  logic [2:0]        r_rw_type;
  logic              r_is_load;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_taken;
  logic              w_ack_done;
  logic              w_timeout;
  logic [LSB_W-1:0]  w_off;
  logic [BE_W-1:0]   w_mask;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept && w_is_mem && !w_misalign) w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (w_ack_done || w_timeout)             w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Handshake, access decode and branch condition.
  always_comb begin
    in_ready   = (r_state == IDLE) && (!out_valid || out_ready);
    w_accept   = in_valid && in_ready;
    w_is_mem   = mem_read || mem_write;
    w_off      = alu_result[LSB_W-1:0];
    w_misalign = 1'b0;
    w_mask     = '1;
    case (rw_type[1:0])
      2'b00: w_mask = BE_W'(1);
      2'b01: begin w_mask = BE_W'(3);  w_misalign = alu_result[0];         end
      2'b10: begin w_mask = BE_W'(15); w_misalign = |alu_result[1:0];      end
      default: begin w_mask = '1;      w_misalign = |alu_result[2:0];      end
    endcase
    w_misalign = w_misalign && w_is_mem;
    case (br_cond)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
    w_taken    = jump || (branch && w_taken);
    w_ack_done = (r_state == WAIT_ACK) && bus_ack;
    w_timeout  = (r_state == WAIT_ACK) && !bus_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Load lane alignment and extension.
  always_comb begin
    w_sh = bus_rdata >> {r_off, 3'b000};
    case (r_rw_type)
      3'b000:  w_load = DATA_W'($signed(w_sh[7:0]));
      3'b001:  w_load = DATA_W'($signed(w_sh[15:0]));
      3'b010:  w_load = DATA_W'($signed(w_sh[31:0]));
      3'b100:  w_load = DATA_W'(w_sh[7:0]);
      3'b101:  w_load = DATA_W'(w_sh[15:0]);
      3'b110:  w_load = DATA_W'(w_sh[31:0]);
      default: w_load = w_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      rd_data     <= '0;
      pc_incr_out <= '0;
      pc_src      <= 1'b0;
      pc_target   <= '0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      r_cnt       <= '0;
      r_off       <= '0;
      r_rw_type   <= '0;
      r_is_load   <= 1'b0;
    end else if (w_accept) begin
      pc_incr_out <= pc_incr_in;
      pc_target   <= pc_offset_in;
      pc_src      <= w_taken;
      misalign    <= w_misalign;
      bus_err     <= 1'b0;
      r_off       <= w_off;
      r_rw_type   <= rw_type;
      r_is_load   <= mem_read && !mem_write;
      if (w_is_mem && !w_misalign) begin
        out_valid <= 1'b0;
        rd_data   <= '0;
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {alu_result[DATA_W-1:LSB_W], LSB_W'(0)};
        bus_wdata <= rs2_data << {w_off, 3'b000};
        bus_be    <= w_mask << w_off;
        r_cnt     <= '0;
      end else begin
        out_valid <= 1'b1;
        rd_data   <= w_misalign ? '0 : alu_result;
      end
    end else if (w_ack_done) begin
      bus_req   <= 1'b0;
      out_valid <= 1'b1;
      rd_data   <= r_is_load ? w_load : '0;
    end else if (w_timeout) begin
      bus_req   <= 1'b0;
      out_valid <= 1'b1;
      bus_err   <= 1'b1;
      rd_data   <= '0;
    end else begin
      if (r_state == WAIT_ACK) r_cnt <= CNT_W'(r_cnt + 1'b1);
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (DATA_W=32, TIMEOUT=4) with an expected-result queue.
module tb_mem_stage_hs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0, rs2_data = '0, pc_incr_in = '0, pc_offset_in = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  rw_type = '0;
  logic        branch = 1'b0, jump = 1'b0;
  logic [2:0]  br_cond = '0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rd_data, pc_incr_out, pc_target;
  logic        pc_src, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  typedef struct {
    logic [31:0] rd;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] inc;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_hs #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .pc_incr_in(pc_incr_in),
    .pc_offset_in(pc_offset_in), .mem_read(mem_read), .mem_write(mem_write),
    .rw_type(rw_type), .branch(branch), .jump(jump), .br_cond(br_cond),
    .zero(zero), .lt(lt), .ltu(ltu), .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .pc_incr_out(pc_incr_out), .pc_src(pc_src),
    .pc_target(pc_target), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic src, input logic [31:0] tgt,
                              input logic mis, input logic err);
    exp_t e;
    e.rd = rd; e.src = src; e.tgt = tgt; e.inc = tgt ^ 32'h4; e.mis = mis; e.err = err;
    return e;
  endfunction

  task automatic issue(input string tag, input logic [31:0] alu, rs2, poff,
                       input logic mr, mw, input logic [2:0] rw, input logic br, jmp,
                       input logic [2:0] cond, input logic z, l, lu);
    alu_result = alu; rs2_data = rs2; pc_offset_in = poff; pc_incr_in = poff ^ 32'h4;
    mem_read = mr; mem_write = mw; rw_type = rw; branch = br; jump = jmp;
    br_cond = cond; zero = z; lt = l; ltu = lu; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, then checks the result against the queue head.
  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (out_valid === 1'b1 && sb.size() > 0) begin
      cur = sb.pop_front();
      chk({tag, "_rd_data"},   64'(rd_data),     64'(cur.rd));
      chk({tag, "_pc_src"},    64'(pc_src),      64'(cur.src));
      chk({tag, "_pc_target"}, 64'(pc_target),   64'(cur.tgt));
      chk({tag, "_pc_incr"},   64'(pc_incr_out), 64'(cur.inc));
      chk({tag, "_misalign"},  64'(misalign),    64'(cur.mis));
      chk({tag, "_bus_err"},   64'(bus_err),     64'(cur.err));
    end
  endtask

  initial begin
    int cnt;
    // Reset values
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_be", 64'(bus_be), 64'd0);
    chk("rst_pc_target", 64'(pc_target), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ALU pass-through
    sb.push_back(mk(32'h1234, 1'b0, 32'h2000, 1'b0, 1'b0));
    issue("alu", 32'h1234, 0, 32'h2000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    chk("alu_in_ready_after", 64'(in_ready), 64'd1);
    wait_out("alu");

    // Back-to-back non-memory throughput
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(32'hA000 + 32'(k), 1'b0, 32'h3000 + 32'(k * 16), 1'b0, 1'b0));
      issue("thru", 32'hA000 + 32'(k), 0, 32'h3000 + 32'(k * 16), 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
      wait_out("thru");
    end
    step();
    chk("thru_drain", 64'(out_valid), 64'd0);

    // LB / LBU at 0x103
    for (int s = 0; s < 2; s++) begin
      sb.push_back(mk(s == 0 ? 32'hFFFF_FF80 : 32'h0000_0080, 1'b0, 32'h4000, 1'b0, 1'b0));
      issue(s == 0 ? "lb" : "lbu", 32'h103, 0, 32'h4000, 1, 0, s == 0 ? 3'b000 : 3'b100, 0, 0, 3'b000, 0, 0, 0);
      chk("lb_bus_req", 64'(bus_req), 64'd1);
      chk("lb_bus_be", 64'(bus_be), 64'h8);
      chk("lb_bus_addr", 64'(bus_addr), 64'h100);
      chk("lb_bus_we", 64'(bus_we), 64'd0);
      chk("lb_in_ready_wait", 64'(in_ready), 64'd0);
      step();
      chk("lb_in_ready_wait2", 64'(in_ready), 64'd0);
      chk("lb_no_valid", 64'(out_valid), 64'd0);
      bus_rdata = 32'h80FF_0000; bus_ack = 1'b1;
      step();
      bus_ack = 1'b0; bus_rdata = '0;
      chk("lb_req_drop", 64'(bus_req), 64'd0);
      wait_out(s == 0 ? "lb" : "lbu");
      step();
    end

    // SH at 0x22 with output back-pressure
    sb.push_back(mk(32'h0, 1'b0, 32'h5000, 1'b0, 1'b0));
    issue("sh", 32'h22, 32'hABCD, 32'h5000, 0, 1, 3'b001, 0, 0, 3'b000, 0, 0, 0);
    chk("sh_bus_we", 64'(bus_we), 64'd1);
    chk("sh_bus_be", 64'(bus_be), 64'hC);
    chk("sh_bus_wdata", 64'(bus_wdata), 64'hABCD_0000);
    chk("sh_bus_addr", 64'(bus_addr), 64'h20);
    out_ready = 1'b0;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    wait_out("sh");
    for (int h = 0; h < 3; h++) begin
      step();
      chk("sh_hold_valid", 64'(out_valid), 64'd1);
      chk("sh_hold_rd", 64'(rd_data), 64'(cur.rd));
      chk("sh_hold_target", 64'(pc_target), 64'(cur.tgt));
      chk("sh_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("sh_release", 64'(out_valid), 64'd0);

    // Misaligned LW
    sb.push_back(mk(32'h0, 1'b0, 32'h6000, 1'b1, 1'b0));
    issue("mis", 32'h6, 0, 32'h6000, 1, 0, 3'b010, 0, 0, 3'b000, 0, 0, 0);
    chk("mis_no_req", 64'(bus_req), 64'd0);
    wait_out("mis");
    step();

    // Timeout with no ack
    sb.push_back(mk(32'h0, 1'b0, 32'h7000, 1'b0, 1'b1));
    issue("to", 32'h40, 0, 32'h7000, 1, 0, 3'b010, 0, 0, 3'b000, 0, 0, 0);
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 20) begin cnt++; step(); end
    chk("to_req_cycles", 64'(cnt), 64'd4);
    chk("to_valid_now", 64'(out_valid), 64'd1);
    wait_out("to");
    step();

    // Ack on the final wait cycle beats the timeout
    sb.push_back(mk(32'h1234_5678, 1'b0, 32'h7100, 1'b0, 1'b0));
    issue("to_ack", 32'h44, 0, 32'h7100, 1, 0, 3'b010, 0, 0, 3'b000, 0, 0, 0);
    step(); step(); step();
    chk("to_ack_req_still", 64'(bus_req), 64'd1);
    bus_rdata = 32'h1234_5678; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    wait_out("to_ack");
    step();

    // Branch resolution
    sb.push_back(mk(32'h55, 1'b1, 32'h800, 1'b0, 1'b0));
    issue("bne", 32'h55, 0, 32'h800, 0, 0, 3'b000, 1, 0, 3'b001, 0, 0, 0);
    wait_out("bne");
    sb.push_back(mk(32'h56, 1'b0, 32'h900, 1'b0, 1'b0));
    issue("bgeu", 32'h56, 0, 32'h900, 0, 0, 3'b000, 1, 0, 3'b111, 0, 0, 1);
    wait_out("bgeu");
    sb.push_back(mk(32'h57, 1'b1, 32'hA00, 1'b0, 1'b0));
    issue("jal", 32'h57, 0, 32'hA00, 0, 0, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    wait_out("jal");
    sb.push_back(mk(32'h58, 1'b0, 32'hB00, 1'b0, 1'b0));
    issue("blt", 32'h58, 0, 32'hB00, 0, 0, 3'b000, 1, 0, 3'b100, 1, 0, 1);
    wait_out("blt");
    sb.push_back(mk(32'h59, 1'b0, 32'hC00, 1'b0, 1'b0));
    issue("br010", 32'h59, 0, 32'hC00, 0, 0, 3'b000, 1, 0, 3'b010, 1, 1, 1);
    wait_out("br010");
    step();

    // Async reset during WAIT_ACK
    issue("arst", 32'h80, 0, 32'hD00, 1, 0, 3'b010, 0, 0, 3'b000, 0, 0, 0);
    chk("arst_req_before", 64'(bus_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus_req", 64'(bus_req), 64'd0);
    chk("arst_bus_addr", 64'(bus_addr), 64'd0);
    chk("arst_pc_target", 64'(pc_target), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    step();

    // Normal operation after reset
    sb.push_back(mk(32'hBEEF, 1'b0, 32'hE00, 1'b0, 1'b0));
    issue("post_rst", 32'hBEEF, 0, 32'hE00, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    wait_out("post_rst");
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Handshaked, parametrised memory stage for the pipelined CPU, sitting between EX and WB. It drives a request/acknowledge data bus with byte enables and stalls upstream for as long as the bus needs. It aligns and sign-extends load data, rejects misaligned accesses, and times out a dead bus. It resolves all six branch conditions and registers the PC-redirect to IF.

## Interface

Parameters:
- DATA_W, 32: data bus width; 32 or 64. BE_W = DATA_W/8; LSB_W = log2(BE_W).
- TIMEOUT, 255: maximum wait cycles for `bus_ack` before the access is abandoned; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage accepts this cycle; equals `state==IDLE && (!out_valid || out_ready)`.
- alu_result  in  DATA_W  memory address, or pass-through result.
- rs2_data  in  DATA_W  store data, right-aligned.
- pc_incr_in  in  DATA_W  PC+4.
- pc_offset_in  in  DATA_W  branch/jump target.
- mem_read, mem_write  in  1  load / store; both high is illegal and treated as store.
- rw_type  in  3  funct3 size code: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (64 only).
- branch, jump  in  1  control.
- br_cond  in  3  branch funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
- zero, lt, ltu  in  1  ALU compare flags.
- out_valid  out  1  WB result valid.
- out_ready  in  1  WB accepts.
- rd_data  out  DATA_W  load data (extended) or alu_result.
- pc_incr_out  out  DATA_W  registered pc_incr_in.
- pc_src  out  1  redirect IF; qualified by out_valid.
- pc_target  out  DATA_W  registered pc_offset_in.
- misalign, bus_err  out  1  exception flags; qualified by out_valid.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  write.
- bus_addr  out  DATA_W  address with low LSB_W bits cleared.
- bus_wdata  out  DATA_W  store data shifted into its byte lanes.
- bus_be  out  BE_W  byte enables.
- bus_ack  in  1  access complete; bus_rdata valid this cycle.
- bus_rdata  in  DATA_W  read data.

## Operation

- States: IDLE, WAIT_ACK.
- Accept occurs when in_valid && in_ready.
- **Non-memory instruction, or misaligned access.**
  - Output registers load on the accept cycle; out_valid is set; state stays IDLE.
  - For a non-memory instruction, rd_data = alu_result.
  - Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0. In that case rd_data = 0 and misalign = 1, and no bus cycle is issued.
- **Aligned memory access.**
  - On accept, bus_* registers load, bus_req is set, the wait counter clears, and state goes to WAIT_ACK.
  - bus_be is the size mask shifted by addr[LSB_W-1:0]: B = 1 lane, H = 2 lanes, W = 4 lanes, D = all lanes.
  - bus_wdata is rs2_data shifted left by 8×offset.
- **WAIT_ACK.**
  - While bus_ack is low, the counter increments.
  - On bus_ack: bus_req clears and out_valid sets. For a load, rd_data is bus_rdata shifted right by 8×offset, then sign-extended (B/H/W) or zero-extended (BU/HU/WU); a store gives rd_data = 0. State returns to IDLE.
  - When the counter reaches TIMEOUT with no ack: bus_req clears, out_valid sets with bus_err = 1 and rd_data = 0, and state returns to IDLE.
  - An ack arriving in the same cycle as the timeout wins: the access completes normally with no error.
- **Branch resolution** is registered at accept: pc_src = jump || (branch && cond(br_cond)).
- **Output hold.** Outputs hold stable while out_valid && !out_ready. out_valid clears on handshake unless a new accept happens in the same cycle.
- Bus signals are stable while bus_req is high.

## Timing

- Reset (async, rst_n low): state IDLE and every registered output 0, i.e. out_valid, rd_data, pc_incr_out, pc_src, pc_target, misalign, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be.
- After reset, in_ready = 1. A reset during WAIT_ACK drops bus_req immediately.
- Non-memory latency: accept at cycle N, out_valid at N+1.
- Memory latency: accept at N, bus_req high at N+1, ack at cycle M ≥ N+1, out_valid at M+1.
- in_ready is low throughout WAIT_ACK, which gives a back-to-back stall.
- Full throughput for non-memory instructions when out_ready stays high: one accept per cycle.
- Timeout: bus_req high for exactly TIMEOUT cycles, with bus_err at out_valid the following cycle.

## Test plan

- ALU pass-through: alu_result=0x1234 with no mem/branch, out_ready=1. Required: out_valid next cycle, rd_data=0x1234, pc_src=0, in_ready stays 1.
- Load byte, signed and unsigned, DATA_W=32: addr=0x103, bus_rdata=0x80FF_0000 with ack 2 cycles after bus_req.
  - LB: bus_be=4'b1000, bus_addr=0x100, rd_data=0xFFFF_FF80.
  - LBU: rd_data=0x0000_0080.
  - in_ready is low until out_valid.
- Store halfword: addr=0x22, rs2_data=0xABCD. Required: bus_we=1, bus_be=4'b1100, bus_wdata=0xABCD_0000; outputs held across 3 cycles of out_ready=0.
- Misaligned LW at addr=0x6. Required: no bus_req, out_valid next cycle with misalign=1, rd_data=0.
- Timeout, TIMEOUT=4, ack never asserted. Required: bus_req high 4 cycles, then out_valid with bus_err=1. Separately, an ack on the 4th cycle gives bus_err=0.
- Branches: BNE with zero=0 → pc_src=1, pc_target=pc_offset_in. BGEU with ltu=1 → pc_src=0. jump=1 → pc_src=1. Async reset asserted mid-WAIT_ACK → all outputs 0 immediately.
